// File: rtl/fphub_exponent_difference_if.sv
// rtl/fphub_exponent_difference_if.sv - operand/result bundle for the exponent-compare stage
interface fphub_exponent_difference_if #(
   parameter int E = 8,
   parameter int M = 24
);
   localparam int SW = $clog2(M + 1);

   logic          in_valid;
   logic [E-1:0]  Ex;
   logic [E-1:0]  Ey;
   logic          out_valid;
   logic [E:0]    dif;
   logic          X_greater_than_Y;
   logic          exp_equal;
   logic [E-1:0]  abs_dif;
   logic [SW-1:0] shift_amt;
   logic [E-1:0]  Ez;

   // Upstream side: presents operands and observes the registered result.
   modport master (
      output in_valid, Ex, Ey,
      input  out_valid, dif, X_greater_than_Y, exp_equal, abs_dif, shift_amt, Ez
   );

   // Compare stage side.
   modport slave (
      input  in_valid, Ex, Ey,
      output out_valid, dif, X_greater_than_Y, exp_equal, abs_dif, shift_amt, Ez
   );
endinterface

// File: rtl/fphub_exponent_difference.sv
// rtl/fphub_exponent_difference.sv - registered exponent compare and alignment shift for the FPHUB adder
module fphub_exponent_difference #(
   parameter int E = 8,
   parameter int M = 24
) (
   input logic                      clk,
   input logic                      rst_n,
   fphub_exponent_difference_if.slave bus
);
   localparam int SW = $clog2(M + 1);
   localparam logic [31:0] M_U = 32'(M);

   logic [E:0]    w_dif;
   logic          w_x_gt_y;
   logic          w_eq;
   logic [E-1:0]  w_abs;
   logic [SW-1:0] w_shift;
   logic [E-1:0]  w_ez;

   // Compare and derive all result fields from the zero-extended difference.
   always_comb begin
      w_dif    = {1'b0, bus.Ex} - {1'b0, bus.Ey};
      w_eq     = (w_dif == '0);
      w_x_gt_y = ~w_dif[E] & ~w_eq;
      // The E-bit subtraction in the winning direction cannot wrap.
      w_abs    = w_dif[E] ? (bus.Ey - bus.Ex) : (bus.Ex - bus.Ey);
      // Ties pick Ey so this matches the operand swap done downstream.
      w_ez     = w_x_gt_y ? bus.Ex : bus.Ey;
      // Clamp at full width; truncating first would alias large differences.
      if (32'(w_abs) > M_U) begin
         w_shift = SW'(M);
      end else begin
         w_shift = w_abs[SW-1:0];
      end
   end

   // Valid follows in_valid every cycle; data only loads on a valid operand pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid        <= 1'b0;
         bus.dif              <= '0;
         bus.X_greater_than_Y <= 1'b0;
         bus.exp_equal        <= 1'b0;
         bus.abs_dif          <= '0;
         bus.shift_amt        <= '0;
         bus.Ez               <= '0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.dif              <= w_dif;
            bus.X_greater_than_Y <= w_x_gt_y;
            bus.exp_equal        <= w_eq;
            bus.abs_dif          <= w_abs;
            bus.shift_amt        <= w_shift;
            bus.Ez               <= w_ez;
         end
      end
   end
endmodule

// File: tb/tb_fphub_exponent_difference.sv
// tb/tb_fphub_exponent_difference.sv - directed self-checking bench for the exponent-compare stage
module tb_fphub_exponent_difference;
   localparam int E = 8;
   localparam int M = 24;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   fphub_exponent_difference_if #(.E(E), .M(M)) bus ();

   fphub_exponent_difference #(.E(E), .M(M)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
      end
   endtask

   task automatic chk_all(input string tag, input logic ov, input logic [8:0] d,
                          input logic xg, input logic eq, input logic [7:0] ab,
                          input logic [4:0] sh, input logic [7:0] ez);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
      chk({tag, ".dif"}, 32'(bus.dif), 32'(d));
      chk({tag, ".xgt"}, 32'(bus.X_greater_than_Y), 32'(xg));
      chk({tag, ".eq"}, 32'(bus.exp_equal), 32'(eq));
      chk({tag, ".abs_dif"}, 32'(bus.abs_dif), 32'(ab));
      chk({tag, ".shift_amt"}, 32'(bus.shift_amt), 32'(sh));
      chk({tag, ".Ez"}, 32'(bus.Ez), 32'(ez));
   endtask

   task automatic step(input logic v, input logic [7:0] ex, input logic [7:0] ey);
      bus.in_valid = v;
      bus.Ex       = ex;
      bus.Ey       = ey;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.Ex       = '0;
      bus.Ey       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 9'h000, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0);
      rst_n = 1'b1;

      step(1'b1, 8'd130, 8'd127);
      chk_all("x130_y127", 1'b1, 9'h003, 1'b1, 1'b0, 8'd3, 5'd3, 8'd130);
      step(1'b1, 8'd127, 8'd130);
      chk_all("x127_y130", 1'b1, 9'h1FD, 1'b0, 1'b0, 8'd3, 5'd3, 8'd130);
      step(1'b1, 8'd100, 8'd100);
      chk_all("x100_y100", 1'b1, 9'h000, 1'b0, 1'b1, 8'd0, 5'd0, 8'd100);
      step(1'b1, 8'd255, 8'd0);
      chk_all("x255_y0", 1'b1, 9'h0FF, 1'b1, 1'b0, 8'd255, 5'd24, 8'd255);
      step(1'b1, 8'd0, 8'd255);
      chk_all("x0_y255", 1'b1, 9'h101, 1'b0, 1'b0, 8'd255, 5'd24, 8'd255);
      step(1'b1, 8'd150, 8'd125);
      chk_all("diff25", 1'b1, 9'h019, 1'b1, 1'b0, 8'd25, 5'd24, 8'd150);
      step(1'b1, 8'd149, 8'd125);
      chk_all("diff24", 1'b1, 9'h018, 1'b1, 1'b0, 8'd24, 5'd24, 8'd149);
      step(1'b1, 8'd125, 8'd148);
      chk_all("diff_m23", 1'b1, 9'h1E9, 1'b0, 1'b0, 8'd23, 5'd23, 8'd148);
      step(1'b1, 8'd0, 8'd0);
      chk_all("x0_y0", 1'b1, 9'h000, 1'b0, 1'b1, 8'd0, 5'd0, 8'd0);

      step(1'b0, 8'd77, 8'd33);
      chk_all("idle_hold", 1'b0, 9'h000, 1'b0, 1'b1, 8'd0, 5'd0, 8'd0);

      step(1'b1, 8'd10, 8'd20);
      chk_all("burst0", 1'b1, 9'h1F6, 1'b0, 1'b0, 8'd10, 5'd10, 8'd20);
      step(1'b1, 8'd200, 8'd199);
      chk_all("burst1", 1'b1, 9'h001, 1'b1, 1'b0, 8'd1, 5'd1, 8'd200);
      step(1'b1, 8'd50, 8'd50);
      chk_all("burst2", 1'b1, 9'h000, 1'b0, 1'b1, 8'd0, 5'd0, 8'd50);
      step(1'b1, 8'd0, 8'd30);
      chk_all("burst3", 1'b1, 9'h1E2, 1'b0, 1'b0, 8'd30, 5'd24, 8'd30);
      step(1'b0, 8'd200, 8'd1);
      chk_all("after0", 1'b0, 9'h1E2, 1'b0, 1'b0, 8'd30, 5'd24, 8'd30);
      step(1'b0, 8'd5, 8'd250);
      chk_all("after1", 1'b0, 9'h1E2, 1'b0, 1'b0, 8'd30, 5'd24, 8'd30);

      step(1'b1, 8'd255, 8'd0);
      chk_all("pre_rst", 1'b1, 9'h0FF, 1'b1, 1'b0, 8'd255, 5'd24, 8'd255);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 9'h000, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0);
      @(posedge clk);
      #1;
      chk_all("rst_held", 1'b0, 9'h000, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0);
      rst_n = 1'b1;
      step(1'b0, 8'd9, 8'd1);
      chk_all("post_rst_idle", 1'b0, 9'h000, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0);
      step(1'b1, 8'd3, 8'd7);
      chk_all("post_rst_op", 1'b1, 9'h1FC, 1'b0, 1'b0, 8'd4, 5'd4, 8'd7);
      step(1'b0, 8'd0, 8'd0);
      chk("post_rst_drop", 32'(bus.out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fphub_exponent_difference.md
Name:
fphub_exponent_difference

Overview:
- Registered exponent-compare stage for the FPHUB floating-point adder.
- Compares two biased exponents and produces:
  - the signed difference;
  - which operand has the larger exponent;
  - that larger exponent (result exponent before normalisation);
  - a right-shift amount, clamped to the mantissa width, used to align the smaller operand's mantissa.
- Fixed latency of one clock, with a valid qualifier.

Parameters:
- E, 8, exponent width in bits.
- M, 24, mantissa width including the implicit 1; used only to clamp shift_amt.
- SW, $clog2(M+1), width of shift_amt (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Ex/Ey are valid this cycle.
- Ex  input  E  biased exponent of operand X.
- Ey  input  E  biased exponent of operand Y.
- out_valid  output  1  outputs hold the result of the operands accepted the previous cycle.
- dif  output  E+1  Ex − Ey, two's complement, sign in bit E.
- X_greater_than_Y  output  1  1 iff Ex > Ey (unsigned), else 0.
- exp_equal  output  1  1 iff Ex == Ey.
- abs_dif  output  E  |Ex − Ey|.
- shift_amt  output  SW  min(abs_dif, M).
- Ez  output  E  max(Ex, Ey); equals Ey when equal.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every output register: out_valid=0, dif=0, X_greater_than_Y=0, exp_equal=0, abs_dif=0, shift_amt=0, Ez=0.
  - Outputs stay cleared while rst_n is low.
  - Asserting reset mid-operation discards the in-flight result; the first out_valid after release follows the first in_valid sampled after release.
- Pipeline:
  - out_valid <= in_valid every cycle.
  - Data registers load only when in_valid=1 and hold their previous values when in_valid=0.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle with no stall or backpressure.
- Arithmetic (combinational, then registered):
  - Zero-extend Ex and Ey to E+1 bits; dif = {1'b0,Ex} − {1'b0,Ey}, modulo 2^(E+1).
  - The result never overflows, because the range −(2^E−1)..+(2^E−1) fits in E+1 bits.
  - X_greater_than_Y = ~dif[E] & (dif != 0), which is equivalent to an unsigned Ex > Ey.
  - exp_equal = (dif == 0).
  - abs_dif = dif[E] ? (Ey − Ex) : (Ex − Ey), truncated to E bits, which is lossless.
  - Ez = X_greater_than_Y ? Ex : Ey. On ties Ey is chosen; the downstream adder relies on this, since its operand swap uses the same rule.
  - shift_amt = (abs_dif > M) ? M : abs_dif[SW-1:0]. The compare must be done at full E-bit width before truncation.
- Boundary conditions:
  - Ex=Ey=0: all result bits 0 and exp_equal=1.
  - Ex=all-ones, Ey=0: dif=2^E−1, abs_dif=2^E−1, shift_amt=M.
  - Ex=0, Ey=all-ones: dif=2^E+1 in E+1 bits (that is, −(2^E−1)).
  - Special exponent encodings (all-ones/zero) receive no special treatment here; they are handled elsewhere.
- Consistency checks:
  - Exactly one of X_greater_than_Y, exp_equal, or "Ey>Ex" (dif[E]) holds.
  - For any registered result, Ez − (X_greater_than_Y ? Ey : Ex) == abs_dif.

Test Plan:
- E=8, M=24. Reset with rst_n=0, then in_valid=1, Ex=130, Ey=127 → next cycle: out_valid=1, dif=9'h003, X_greater_than_Y=1, exp_equal=0, abs_dif=3, shift_amt=3, Ez=130.
- Ex=127, Ey=130 → dif=9'h1FD, X_greater_than_Y=0, exp_equal=0, abs_dif=3, shift_amt=3, Ez=130.
- Ex=100, Ey=100 → dif=0, X_greater_than_Y=0, exp_equal=1, abs_dif=0, shift_amt=0, Ez=100.
- Ex=255, Ey=0 → dif=9'h0FF, abs_dif=255, shift_amt=24, Ez=255. Ex=0, Ey=255 → dif=9'h101, X_greater_than_Y=0, shift_amt=24, Ez=255. Ex=150, Ey=125 (diff 25) → shift_amt=24. Ex=149, Ey=125 (diff 24) → shift_amt=24.
- Back-to-back in_valid for 4 cycles, then in_valid=0 → out_valid high for exactly 4 cycles with the matching results in order; data outputs then hold the last result.
- Assert rst_n=0 asynchronously between clock edges while in_valid=1 → all outputs go to 0 immediately without waiting for a clock edge. Release reset, hold in_valid=0 → out_valid stays 0.
